ddr_amm_arbiter: RTL and testbench

Two-requester arbiter that shares the single Avalon-MM DDR port between two local masters, for example the DDR-staging wrapper and a second DMA or checker engine. Commands use burstcount 1. Requesters are served round-robin, and an in-flight command stays locked to its requester until the controller accepts it. Read data is routed back to the issuing requester in order, using a tag FIFO of requester IDs.

---
 rtl/ddr_amm_arbiter.sv | 151 +++++++++++++++
 tb/tb_ddr_amm_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_amm_arbiter.sv
// Two-requester round-robin arbiter for one Avalon-MM DDR port (burstcount 1).
// Read data returns in order and is steered back to its issuer through a tag FIFO.
module ddr_amm_arbiter #(
  parameter int DDR_DATA_WIDTH  = 64,
  parameter int DDR_ADDR_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      local_init_done,
  input  logic [DDR_ADDR_WIDTH-1:0] m0_addr,
  input  logic [DDR_DATA_WIDTH-1:0] m0_wdata,
  input  logic                      m0_ren,
  input  logic                      m0_wen,
  output logic                      m0_wait,
  output logic                      m0_rvalid,
  output logic [DDR_DATA_WIDTH-1:0] m0_rdata,
  input  logic [DDR_ADDR_WIDTH-1:0] m1_addr,
  input  logic [DDR_DATA_WIDTH-1:0] m1_wdata,
  input  logic                      m1_ren,
  input  logic                      m1_wen,
  output logic                      m1_wait,
  output logic                      m1_rvalid,
  output logic [DDR_DATA_WIDTH-1:0] m1_rdata,
  output logic [DDR_ADDR_WIDTH-1:0] amm_addr,
  output logic [DDR_DATA_WIDTH-1:0] amm_wdata,
  output logic                      amm_ren,
  output logic                      amm_wen,
  output logic [5:0]                amm_burstcount,
  input  logic                      amm_wait,
  input  logic                      amm_rvalid,
  input  logic [DDR_DATA_WIDTH-1:0] amm_rdata,
  output logic [CW-1:0]             outstanding,
  output logic                      rsp_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);

  // Handshake: a command transfers in a cycle where it is driven and mi_wait is low;
  // while mi_wait is high the requester must hold addr/wdata/ren/wen stable.

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state, state_nxt;
  logic   lock_id, last_grant;
  logic   gnt_valid, gnt_id;
  logic   elig0, elig1, rd_room;
  logic   accept, push, pop, fifo_empty, head_id;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          tag_mem [MAX_OUTSTANDING];

  assign rd_room    = (outstanding < CW'(MAX_OUTSTANDING));
  assign elig0      = local_init_done & (m0_wen | (m0_ren & rd_room));
  assign elig1      = local_init_done & (m1_wen | (m1_ren & rd_room));
  assign fifo_empty = (outstanding == '0);
  assign head_id    = tag_mem[rd_ptr];

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == LOCKED) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id;
    end else if (elig0 && elig1) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_grant;
    end else if (elig0 || elig1) begin
      gnt_valid = 1'b1;
      gnt_id    = elig1;
    end
  end

  // A simultaneous write request wins over a read on the same port.
  always_comb begin
    amm_addr  = '0;
    amm_wdata = '0;
    amm_wen   = 1'b0;
    amm_ren   = 1'b0;
    m0_wait   = 1'b1;
    m1_wait   = 1'b1;
    if (gnt_valid) begin
      if (gnt_id) begin
        amm_addr  = m1_addr;
        amm_wdata = m1_wdata;
        amm_wen   = m1_wen & local_init_done;
        amm_ren   = m1_ren & ~m1_wen & local_init_done;
        m1_wait   = amm_wait | ~local_init_done;
      end else begin
        amm_addr  = m0_addr;
        amm_wdata = m0_wdata;
        amm_wen   = m0_wen & local_init_done;
        amm_ren   = m0_ren & ~m0_wen & local_init_done;
        m0_wait   = amm_wait | ~local_init_done;
      end
    end
  end

  assign accept = gnt_valid & local_init_done & ~amm_wait;
  assign push   = accept & amm_ren;
  assign pop    = amm_rvalid & ~fifo_empty;

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = IDLE;
    else if (gnt_valid && amm_wait)
      state_nxt = LOCKED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lock_id     <= 1'b0;
      last_grant  <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_valid && amm_wait)
        lock_id <= gnt_id;
      if (accept)
        last_grant <= gnt_id;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        outstanding <= outstanding + 1'b1;
      else if (pop && !push)
        outstanding <= outstanding - 1'b1;
      if (amm_rvalid && fifo_empty)
        rsp_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= gnt_id;
  end

  assign m0_rvalid      = pop & ~head_id;
  assign m1_rvalid      = pop & head_id;
  assign m0_rdata       = amm_rdata;
  assign m1_rdata       = amm_rdata;
  assign amm_burstcount = 6'd1;

endmodule

// File: tb/tb_ddr_amm_arbiter.sv
// Directed bench for ddr_amm_arbiter: arbitration order, wait-request locking,
// tag-routed read returns, outstanding limit and the sticky response error.
module tb_ddr_amm_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MO = 8;
  localparam int CW = $clog2(MO) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          local_init_done;
  logic [AW-1:0] m0_addr, m1_addr, amm_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, amm_wdata, m0_rdata, m1_rdata, amm_rdata;
  logic          m0_ren, m0_wen, m1_ren, m1_wen;
  logic          m0_wait, m1_wait, m0_rvalid, m1_rvalid;
  logic          amm_ren, amm_wen, amm_wait, amm_rvalid;
  logic [5:0]    amm_burstcount;
  logic [CW-1:0] outstanding;
  logic          rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [0:0]  exp_q[$];
  logic [0:0]  exp_id;
  logic [63:0] rd_data [4];
  logic [0:0]  rd_port [4];
  int cnt0, cnt1;

  ddr_amm_arbiter #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .local_init_done(local_init_done),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ren(m0_ren), .m0_wen(m0_wen),
    .m0_wait(m0_wait), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ren(m1_ren), .m1_wen(m1_wen),
    .m1_wait(m1_wait), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .amm_addr(amm_addr), .amm_wdata(amm_wdata), .amm_ren(amm_ren), .amm_wen(amm_wen),
    .amm_burstcount(amm_burstcount), .amm_wait(amm_wait), .amm_rvalid(amm_rvalid),
    .amm_rdata(amm_rdata), .outstanding(outstanding), .rsp_err(rsp_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_wdata = '0; m0_ren = 0; m0_wen = 0;
    m1_addr = '0; m1_wdata = '0; m1_ren = 0; m1_wen = 0;
    amm_wait = 0; amm_rvalid = 0; amm_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    local_init_done = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    settle();

    // reset state
    check("rst_amm_ren", amm_ren, 0);
    check("rst_amm_wen", amm_wen, 0);
    check("rst_amm_addr", amm_addr, 0);
    check("rst_amm_wdata", amm_wdata, 0);
    check("rst_m0_wait", m0_wait, 1);
    check("rst_m1_wait", m1_wait, 1);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    check("rst_burst", amm_burstcount, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_rsp_err", rsp_err, 0);

    // both request before calibration: nothing issued
    m0_wen = 1; m0_addr = 32'h100; m0_wdata = 64'haaaa;
    m1_wen = 1; m1_addr = 32'h200; m1_wdata = 64'hbbbb;
    settle();
    check("noinit_wen", amm_wen, 0);
    check("noinit_m0_wait", m0_wait, 1);
    check("noinit_m1_wait", m1_wait, 1);
    step();
    check("noinit_hold_wen", amm_wen, 0);

    local_init_done = 1;
    settle();
    check("first_addr", amm_addr, 32'h100);
    check("first_wdata", amm_wdata, 64'haaaa);
    check("first_m0_wait", m0_wait, 0);
    check("first_m1_wait", m1_wait, 1);
    step();
    check("second_addr", amm_addr, 32'h200);
    check("second_m1_wait", m1_wait, 0);
    check("second_m0_wait", m0_wait, 1);
    step();

    // continuous writes alternate
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      check("alt_addr", amm_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      check("alt_wen", amm_wen, 1);
      if (amm_addr == 32'h100) cnt0++;
      if (amm_addr == 32'h200) cnt1++;
      step();
    end
    check("alt_cnt0", cnt0, 4);
    check("alt_cnt1", cnt1, 4);
    m0_wen = 0; m1_wen = 0;

    // port 1 read locked by wait-request while port 0 requests
    m1_ren = 1; m1_addr = 32'h300; amm_wait = 1;
    settle();
    check("lock_c0_addr", amm_addr, 32'h300);
    check("lock_c0_ren", amm_ren, 1);
    check("lock_c0_m1_wait", m1_wait, 1);
    step();
    m0_wen = 1; m0_addr = 32'h400;
    for (int c = 1; c < 3; c++) begin
      settle();
      check("lock_addr", amm_addr, 32'h300);
      check("lock_m0_wait", m0_wait, 1);
      step();
    end
    amm_wait = 0;
    settle();
    check("lock_c3_addr", amm_addr, 32'h300);
    check("lock_c3_m1_wait", m1_wait, 0);
    step();
    m1_ren = 0;
    settle();
    check("after_lock_addr", amm_addr, 32'h400);
    check("after_lock_wen", amm_wen, 1);
    check("after_lock_m0_wait", m0_wait, 0);
    step();
    m0_wen = 0;
    settle();
    check("lock_out1", outstanding, 1);
    amm_rvalid = 1; amm_rdata = 64'hdead_beef_0000_0001;
    settle();
    check("ret1_m1_rvalid", m1_rvalid, 1);
    check("ret1_m0_rvalid", m0_rvalid, 0);
    check("ret1_m1_rdata", m1_rdata, 64'hdead_beef_0000_0001);
    step();
    amm_rvalid = 0;
    settle();
    check("ret1_out0", outstanding, 0);

    // interleaved reads m0, m1, m1, m0 then four returns
    rd_port[0] = 0; rd_port[1] = 1; rd_port[2] = 1; rd_port[3] = 0;
    rd_data[0] = 64'h0a; rd_data[1] = 64'h0b; rd_data[2] = 64'h0c; rd_data[3] = 64'h0d;
    for (int i = 0; i < 4; i++) begin
      if (rd_port[i] == 1'b0) begin m0_ren = 1; m0_addr = 32'h500 + i; end
      else begin m1_ren = 1; m1_addr = 32'h500 + i; end
      settle();
      check("il_addr", amm_addr, 32'h500 + i);
      check("il_ren", amm_ren, 1);
      exp_q.push_back(rd_port[i]);
      step();
      m0_ren = 0; m1_ren = 0;
    end
    settle();
    check("il_out4", outstanding, 4);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 4; k++) begin
      amm_rvalid = 1; amm_rdata = rd_data[k];
      settle();
      exp_id = exp_q.pop_front();
      check("il_m0_rvalid", m0_rvalid, (exp_id == 1'b0));
      check("il_m1_rvalid", m1_rvalid, (exp_id == 1'b1));
      check("il_rdata", exp_id ? m1_rdata : m0_rdata, rd_data[k]);
      if (m0_rvalid) cnt0++;
      if (m1_rvalid) cnt1++;
      step();
      amm_rvalid = 0;
      settle();
      check("il_out", outstanding, 3 - k);
    end
    check("il_cnt0", cnt0, 2);
    check("il_cnt1", cnt1, 2);

    // outstanding limit, no same-cycle bypass
    m0_ren = 1; m0_addr = 32'h600;
    for (int i = 0; i < MO; i++) begin
      settle();
      check("fill_m0_wait", m0_wait, 0);
      step();
    end
    check("full_out", outstanding, MO);
    check("full_m0_wait", m0_wait, 1);
    check("full_ren", amm_ren, 0);
    amm_rvalid = 1; amm_rdata = 64'h77;
    settle();
    check("full_pop_m0_wait", m0_wait, 1);
    check("full_pop_rvalid", m0_rvalid, 1);
    step();
    amm_rvalid = 0;
    settle();
    check("full_out7", outstanding, MO - 1);
    check("ninth_m0_wait", m0_wait, 0);
    check("ninth_ren", amm_ren, 1);
    step();
    m0_ren = 0;
    settle();
    check("refull_out", outstanding, MO);
    for (int i = 0; i < MO; i++) begin
      amm_rvalid = 1;
      settle();
      check("drain_m0_rvalid", m0_rvalid, 1);
      check("drain_m1_rvalid", m1_rvalid, 0);
      step();
    end
    amm_rvalid = 0;
    settle();
    check("drain_out0", outstanding, 0);

    // return with empty tag FIFO
    amm_rvalid = 1;
    settle();
    check("err_rvalid", {m0_rvalid, m1_rvalid}, 0);
    step();
    amm_rvalid = 0;
    settle();
    check("err_set", rsp_err, 1);
    check("err_out", outstanding, 0);
    step(); step(); step();
    check("err_sticky", rsp_err, 1);
    rst = 1;
    settle();
    check("err_cleared", rsp_err, 0);
    step();
    rst = 0;

    // reset mid-operation discards pending tags
    m1_ren = 1; m1_addr = 32'h700;
    settle();
    step();
    m1_ren = 0;
    settle();
    check("mid_out1", outstanding, 1);
    rst = 1;
    settle();
    check("mid_rst_out", outstanding, 0);
    step();
    rst = 0;
    amm_rvalid = 1;
    settle();
    check("stale_m1_rvalid", m1_rvalid, 0);
    step();
    amm_rvalid = 0;
    settle();
    check("stale_err", rsp_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
